// File: rtl/uart.sv
// 8N1 full-duplex UART: buffered transmitter and mid-bit sampling receiver.
// Bit period is CLK_FREQ/BAUD clocks.
module uart #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic       txd,
    input  logic       txce,
    input  logic [7:0] tx,
    output logic       rxce,
    output logic [7:0] rx,
    output logic       bsy,
    output logic       txmty,
    output logic       frmero
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE     = 3'd0;
    localparam logic [2:0] RX_START    = 3'd1;
    localparam logic [2:0] RX_DATA     = 3'd2;
    localparam logic [2:0] RX_STOP     = 3'd3;
    localparam logic [2:0] RX_WAITHIGH = 3'd4;

    logic [1:0]    tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic [7:0]    hold;
    logic          hold_full;

    assign txmty = !hold_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            txd       <= 1'b1;
            bsy       <= 1'b0;
        end else begin
            if (txce && !hold_full) begin
                hold      <= tx;
                hold_full <= 1'b1;
            end
            unique case (tx_state)
                TX_IDLE: begin
                    if (hold_full) begin
                        tx_shift  <= hold;
                        hold_full <= 1'b0;
                        tx_cnt    <= '0;
                        txd       <= 1'b0;
                        bsy       <= 1'b1;
                        tx_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        txd      <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            txd      <= tx_shift[1];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == LAST) begin
                        tx_cnt <= '0;
                        // Chain straight into the next start bit when a byte waits
                        if (hold_full) begin
                            tx_shift  <= hold;
                            hold_full <= 1'b0;
                            txd       <= 1'b0;
                            tx_state  <= TX_START;
                        end else begin
                            bsy      <= 1'b0;
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    logic [1:0]    rx_sync;
    logic          rs;
    logic [2:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;

    assign rs = rx_sync[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_sync  <= 2'b11;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx       <= 8'h00;
            rxce     <= 1'b0;
            frmero   <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
            rxce    <= 1'b0;
            unique case (rx_state)
                RX_IDLE: begin
                    if (!rs) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rs ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rs, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt <= '0;
                        if (rs) begin
                            rx       <= rx_shift;
                            rxce     <= 1'b1;
                            frmero   <= 1'b0;
                            rx_state <= RX_IDLE;
                        end else begin
                            frmero   <= 1'b1;
                            rx_state <= RX_WAITHIGH;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_WAITHIGH: begin
                    if (rs) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart.sv
// Randomised and directed bench for uart at DIV=16, compared each cycle
// against a frame-timeline model of the line.
module tb_uart;

    localparam int DIV = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rxd;
    logic       txd;
    logic       txce = 1'b0;
    logic [7:0] tx = 8'h00;
    logic       rxce;
    logic [7:0] rx;
    logic       bsy;
    logic       txmty;
    logic       frmero;

    logic       loop = 1'b1;
    logic       rxd_drv = 1'b1;

    assign rxd = loop ? txd : rxd_drv;

    uart #(.CLK_FREQ(1600), .BAUD(100)) dut (
        .clock (clock),
        .reset (reset),
        .rxd   (rxd),
        .txd   (txd),
        .txce  (txce),
        .tx    (tx),
        .rxce  (rxce),
        .rx    (rx),
        .bsy   (bsy),
        .txmty (txmty),
        .frmero(frmero)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: line timeline derived from when each frame began
    int         c = 0;
    bit         m_act = 0;
    int         m_fs = 0;
    logic [7:0] m_byte = 0;
    bit         m_hv = 0;
    logic [7:0] m_hb = 0;
    int         n_frames = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] m_rx_last = 8'h00;
    int         n_rxce = 0;

    function automatic logic line_bit(input int k, input logic [7:0] b);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    initial begin
        forever begin
            bit pre_hv;
            @(posedge clock or posedge reset);
            if (reset) begin
                m_act = 0;
                m_hv  = 0;
                c     = 0;
            end else begin
                c++;
                pre_hv = m_hv;
                if (m_act && c - m_fs == 10 * DIV) m_act = 0;
                if (!m_act && pre_hv) begin
                    m_act  = 1;
                    m_fs   = c;
                    m_byte = m_hb;
                    m_hv   = 0;
                    n_frames++;
                    if (loop) exp_rx.push_back(m_hb);
                end
                if (txce && !pre_hv) begin
                    m_hv = 1;
                    m_hb = tx;
                end
            end
        end
    end

    initial begin
        bit prev_rxce = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                m_rx_last = 8'h00;
                prev_rxce = 0;
            end else begin
                chk("txd", txd, m_act ? line_bit((c - m_fs) / DIV, m_byte) : 1'b1);
                chk("bsy", bsy, m_act);
                chk("txmty", txmty, !m_hv);
                if (rxce) begin
                    n_rxce++;
                    chk("rxce_width", prev_rxce, 0);
                    if (exp_rx.size() == 0) begin
                        chk("rxce_unexpected", rx, 32'hFFFF_FFFF);
                    end else begin
                        m_rx_last = exp_rx.pop_front();
                        chk("rx_byte", rx, m_rx_last);
                    end
                end else begin
                    chk("rx_hold", rx, m_rx_last);
                end
                prev_rxce = rxce;
            end
        end
    end

    task automatic pulse_tx(input logic [7:0] b);
        @(negedge clock);
        tx   = b;
        txce = 1'b1;
        @(negedge clock);
        txce = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_act || m_hv) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("idle_timeout", n < 2000, 1);
        repeat (40) @(negedge clock);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rxd_drv = 1'b0;
        repeat (DIV) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (DIV) @(negedge clock);
        end
        rxd_drv = stop;
        repeat (DIV) @(negedge clock);
    endtask

    initial begin
        int         base;
        logic [7:0] a7 = 8'hA7;
        logic [9:0] pat;
        pat = {1'b1, a7, 1'b0};

        #1 reset = 1'b1;
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_txmty", txmty, 1);
        chk("rst_bsy", bsy, 0);
        chk("rst_rxce", rxce, 0);
        chk("rst_frmero", frmero, 0);
        chk("rst_rx", rx, 8'h00);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // single transmit, literal line pattern
        base = n_rxce;
        @(negedge clock);
        tx   = 8'hA7;
        txce = 1'b1;
        @(negedge clock);
        txce = 1'b0;
        chk("a7_pre_start", txd, 1);
        chk("a7_txmty_full", txmty, 0);
        @(negedge clock);
        chk("a7_start", txd, 0);
        chk("a7_bsy", bsy, 1);
        chk("a7_txmty_back", txmty, 1);
        repeat (8) @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("a7_bit%0d", i), txd, pat[i]);
            if (i < 9) repeat (DIV) @(negedge clock);
        end
        repeat (8) @(negedge clock);
        chk("a7_end_bsy", bsy, 0);
        chk("a7_end_txd", txd, 1);
        pulse_tx(8'h00);
        wait_idle();
        chk("loop_count", n_rxce - base, 2);
        chk("loop_last", rx, 8'h00);
        chk("loop_frmero", frmero, 0);

        // back-to-back with a dropped third strobe
        base = n_frames;
        @(negedge clock);
        tx   = 8'h55;
        txce = 1'b1;
        @(negedge clock);
        txce = 1'b0;
        @(negedge clock);
        tx   = 8'hC3;
        txce = 1'b1;
        @(negedge clock);
        tx   = 8'hFF;
        @(negedge clock);
        txce = 1'b0;
        repeat (158) @(negedge clock);
        chk("b2b_start", txd, 0);
        chk("b2b_bsy", bsy, 1);
        wait_idle();
        chk("b2b_frames", n_frames - base, 2);
        chk("b2b_last", rx, 8'hC3);

        // randomised loopback traffic
        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 250)) @(negedge clock);
            pulse_tx(8'($urandom));
        end
        wait_idle();
        chk("rand_drained", exp_rx.size(), 0);
        chk("rand_frmero", frmero, 0);

        // frame error then recovery
        loop = 1'b0;
        base = n_rxce;
        send_rx(8'h3C, 1'b0);
        repeat (20) @(negedge clock);
        chk("ferr_flag", frmero, 1);
        chk("ferr_no_rxce", n_rxce - base, 0);
        chk("ferr_rx_kept", rx, m_rx_last);
        rxd_drv = 1'b1;
        repeat (32) @(negedge clock);
        chk("ferr_sticky", frmero, 1);
        exp_rx.push_back(8'h81);
        send_rx(8'h81, 1'b1);
        repeat (20) @(negedge clock);
        chk("rec_rxce", n_rxce - base, 1);
        chk("rec_rx", rx, 8'h81);
        chk("rec_frmero", frmero, 0);

        // short low glitch is ignored
        base = n_rxce;
        rxd_drv = 1'b0;
        repeat (4) @(negedge clock);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clock);
        chk("glitch_rxce", n_rxce - base, 0);
        chk("glitch_frmero", frmero, 0);
        exp_rx.push_back(8'hF0);
        send_rx(8'hF0, 1'b1);
        repeat (20) @(negedge clock);
        chk("glitch_next", rx, 8'hF0);
        chk("glitch_count", n_rxce - base, 1);

        // reset in the middle of a transmit frame
        pulse_tx(8'h5A);
        repeat (50) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_txd", txd, 1);
        chk("mid_rst_bsy", bsy, 0);
        chk("mid_rst_txmty", txmty, 1);
        chk("mid_rst_rx", rx, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("post_rst_txd", txd, 1);
        chk("post_rst_q", exp_rx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart.md
Name: uart

Overview:
- Full-duplex 8N1 UART: 8 data bits, no parity, 1 stop bit, LSB first.
- Transmit path: one-byte holding register feeding a shift register.
- Receive path: synchronised, mid-bit-sampling receiver with frame-error detection.
- Sits between the FPGA fabric (50 MHz derived clock) and the board serial pins; used by the echo/miner host link.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. DIV = CLK_FREQ/BAUD (integer division; 434 at defaults) clocks per bit. DIV must be at least 4.

Ports:
clock   input   1  system clock; all logic on rising edge
reset   input   1  asynchronous, active-high reset
rxd     input   1  serial receive line, asynchronous, idle high
txd     output  1  serial transmit line, idle high
txce    input   1  transmit strobe; loads tx into holding register when txmty=1
tx      input   8  byte to transmit, sampled with txce
rxce    output  1  one-cycle pulse: new valid byte on rx
rx      output  8  last correctly received byte
bsy     output  1  transmit shifter active (start, data or stop bit on line)
txmty   output  1  transmit holding register empty; can accept txce
frmero  output  1  frame error flag

Behaviour:
- Reset (async, immediate) sets: txd=1, rxce=0, rx=8'h00, bsy=0, txmty=1, frmero=0. Both FSMs go to IDLE and all counters clear.
- TX holding register:
  - txce=1 at a clock edge with txmty=1: tx is captured and txmty=0 from the next cycle.
  - txce while txmty=0: ignored; the byte is lost and there is no error.
- TX shifter (states IDLE, START, DATA, STOP):
  - IDLE with holding register full: the byte moves to the shifter on the next edge, txmty returns to 1, bsy=1, and txd drives the start bit (0). The start bit therefore begins 2 cycles after the accepted txce.
  - Each bit is held exactly DIV cycles.
  - Order: start 0, then d0..d7, then stop 1.
  - After the stop bit's DIV cycles:
    - Holding register full: next start bit begins on the next cycle (back-to-back, no idle gap); bsy stays 1.
    - Otherwise: bsy=0 and txd=1.
  - txd is registered (glitch-free).
- RX:
  - rxd passes through a 2-flop synchroniser before any use.
  - States: IDLE, START, DATA, STOP, WAITHIGH.
  - IDLE: a synchronised low moves to START.
  - START: sample at DIV/2 cycles.
    - Still low: move to DATA.
    - High: glitch; return to IDLE with no flag.
  - DATA: sample every DIV cycles (bit centres) 8 times, LSB first.
  - STOP: sample one further DIV cycles later.
    - Stop=1: rx <= shifted byte, rxce=1 for exactly one cycle, frmero <= 0, back to IDLE.
    - Stop=0: frmero <= 1, rx unchanged, no rxce; go to WAITHIGH.
  - WAITHIGH: stay until the synchronised line is high, then return to IDLE.
  - frmero stays asserted until the next valid frame clears it.
- TX and RX are fully independent; simultaneous activity is allowed.
- Reset mid-frame: txd returns high immediately. A partially received byte is discarded.

Test Plan:
- Reset check: assert reset with no clock edge -> txd=1, txmty=1, bsy=0, rxce=0, frmero=0, rx=00.
- Single transmit: override CLK_FREQ=1600, BAUD=100 (DIV=16); pulse txce with tx=8'hA7 -> txd goes low 2 cycles later. Line is 0,1,1,1,0,0,1,0,1,1, each bit 16 cycles. bsy high for 160 cycles, then txd=1 and bsy=0.
- Back-to-back: txce 8'h55, then txce 8'hC3 once txmty=1 -> the second frame's start bit immediately follows the first frame's stop bit. A third txce issued while txmty=0 is ignored (only 2 frames emitted).
- Loopback: txd tied to rxd, send 8'hA7 then 8'h00 -> two rxce pulses, each exactly 1 cycle wide, with rx=A7 then 00; frmero stays 0.
- Frame error and recovery: drive a frame for 8'h3C with stop bit 0, then a valid 8'h81 -> frmero=1 with no rxce and rx unchanged. After the line returns high, the next frame gives rx=81 with an rxce pulse and frmero=0.
- Glitch rejection: rxd low for 4 cycles (< DIV/2), then high -> no rxce, no frmero, receiver back in IDLE. A following valid 8'hF0 is received correctly.
